// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between fetch and decode.
//
// Captures {pc, instr} pairs on each fetch memory response and presents them
// in order to decode over a valid/ready handshake. A flush (redirect) drops
// every buffered entry. Storage is a circular buffer of 2**DEPTH_LOG2 entries.
//
// Parameters:
//   DEPTH_LOG2  log2 of entry count (legal 1..4)
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   fetch response strobe
//   in_pc      in   pc of the returned instruction
//   in_instr   in   instruction word from memory
//   in_ready   out  queue can accept an entry this cycle (registered state only)
//   out_valid  out  head entry valid for decode
//   out_pc     out  pc of head entry
//   out_instr  out  instruction of head entry
//   out_ready  in   decode consumes head this cycle
//   flush      in   redirect, discard all entries
//   overflow   out  sticky: in_valid seen while in_ready=0, cleared only by reset
//
// Optional feature macro: FETCHQ_BYPASS_EN
//   When defined, an empty queue forwards in_pc/in_instr straight to out_* in
//   the same cycle; if decode also takes it, the entry is never written.
//   When undefined there is no combinational path from in_* to out_*.

module fetch_queue #(
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_instr,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        out_ready,
   input  logic        flush,
   output logic        overflow
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam int unsigned CntW  = DEPTH_LOG2 + 1;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [CntW-1:0]       cnt_t;

   localparam cnt_t CountFull = cnt_t'(Depth);

   // State
   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   cnt_t        count_q, count_d;
   logic        overflow_q, overflow_d;
   logic [31:0] pc_mem_q    [Depth];
   logic [31:0] pc_mem_d    [Depth];
   logic [31:0] instr_mem_q [Depth];
   logic [31:0] instr_mem_d [Depth];

   logic empty;
   logic full;
   logic push;
   logic pop;
   logic drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CountFull);

   // A pop in the same cycle never makes room: readiness is purely registered.
   assign in_ready = ~full;
   assign overflow = overflow_q;

`ifdef FETCHQ_BYPASS_EN
   logic bypass;
   logic bypass_take;

   // Empty queue forwards the incoming response directly to decode.
   assign bypass      = empty & in_valid & ~flush;
   assign bypass_take = bypass & out_ready;

   assign out_valid = (~empty | in_valid) & ~flush;
   assign out_pc    = empty ? in_pc    : pc_mem_q[rd_ptr_q];
   assign out_instr = empty ? in_instr : instr_mem_q[rd_ptr_q];

   // A bypassed entry consumed this cycle is never written.
   assign push = in_valid & in_ready & ~flush & ~bypass_take;
`else
   assign out_valid = ~empty & ~flush;
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_instr = instr_mem_q[rd_ptr_q];

   assign push = in_valid & in_ready & ~flush;
`endif

   // Only stored entries are popped; a bypassed hand-off leaves storage alone.
   assign pop  = out_valid & out_ready & ~empty;
   assign drop = in_valid & ~in_ready & ~flush;

   // Next-state logic
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | drop;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;

      if (flush) begin
         // Everything buffered is discarded; realign read to write.
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]    = in_pc;
            instr_mem_d[wr_ptr_q] = in_instr;
            wr_ptr_d              = wr_ptr_q + ptr_t'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state, asynchronously reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage is intentionally not reset; contents are qualified by count.
   always_ff @(posedge clk) begin
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a
// queue-based reference model of the buffer's observable behaviour.

module tb_fetch_queue;

   localparam int unsigned DepthLog2 = 2;
   localparam int unsigned Depth     = 2 ** DepthLog2;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;
   logic        flush;
   logic        overflow;

   int checks;
   int failures;

   // Reference model: queue of {pc, instr}, plus sticky overflow.
   logic [63:0] mq[$];
   logic        m_ovf;

`ifdef FETCHQ_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   fetch_queue #(.DEPTH_LOG2(DepthLog2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_ready (out_ready),
      .flush     (flush),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, check combinational outputs mid-cycle, then
   // advance the model and the DUT across the next rising edge.
   task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy, input logic fl);
      logic        exp_ready;
      logic        exp_valid;
      logic [63:0] exp_head;
      logic        take_stored;
      logic        take_bypass;
      in_valid  = iv;
      in_pc     = pc;
      in_instr  = ins;
      out_ready = ordy;
      flush     = fl;

      exp_ready = (mq.size() != Depth);
      exp_valid = !fl && (mq.size() != 0 || (Bypass && iv));
      exp_head  = (mq.size() != 0) ? mq[0] : {pc, ins};

      @(negedge clk);
      chk1({tag, ".in_ready"}, in_ready, exp_ready);
      chk1({tag, ".out_valid"}, out_valid, exp_valid);
      chk1({tag, ".overflow"}, overflow, m_ovf);
      if (exp_valid) begin
         chk32({tag, ".out_pc"}, out_pc, exp_head[63:32]);
         chk32({tag, ".out_instr"}, out_instr, exp_head[31:0]);
      end

      take_stored = exp_valid && ordy && (mq.size() != 0);
      take_bypass = exp_valid && ordy && (mq.size() == 0);
      if (fl) begin
         mq.delete();
      end else begin
         if (iv && !exp_ready) m_ovf = 1'b1;
         if (take_stored) void'(mq.pop_front());
         if (iv && exp_ready && !take_bypass) mq.push_back({pc, ins});
      end

      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_ovf    = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      out_ready = 1'b0;
      flush     = 1'b0;

      // Reset values are visible while reset is held.
      #12;
      chk1("reset.in_ready", in_ready, 1'b1);
      chk1("reset.out_valid", out_valid, 1'b0);
      chk1("reset.overflow", overflow, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle("idle");

      // Fill with out_ready low.
      for (int i = 0; i < 4; i++) begin
         step("fill", 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
      end
      idle("full");
      chk1("full.in_ready_low", in_ready, 1'b0);
      chk32("full.head_pc", out_pc, 32'h0);

      // Drain in order.
      for (int i = 0; i < 4; i++) begin
         step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      idle("drained");

      // Full plus simultaneous push/pop: only the pop happens, overflow sets.
      for (int i = 0; i < 4; i++) begin
         step("refill", 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
      end
      step("full_simul", 1'b1, 32'h10, $urandom, 1'b1, 1'b0);
      chk1("full_simul.overflow", overflow, 1'b1);
      chk32("full_simul.head_pc", out_pc, 32'h4);
      chk32("full_simul.model_count", 32'(mq.size()), 32'd3);
      idle("after_simul");

      // Flush with a concurrent push: both discarded.
      step("flush", 1'b1, 32'h40, $urandom, 1'b0, 1'b1);
      idle("post_flush");
      chk1("post_flush.in_ready", in_ready, 1'b1);
      step("push80", 1'b1, 32'h80, $urandom, 1'b0, 1'b0);
      idle("see80");
      chk32("see80.pc", out_pc, 32'h80);
      step("pop80", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Steady stream of 9 entries wraps the pointers.
      for (int i = 0; i < 9; i++) begin
         step("stream", 1'b1, 32'h200 + 32'(i * 4), $urandom, 1'b1, 1'b0);
      end
      step("stream_tail", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      idle("stream_done");

      // Empty queue, in_valid and out_ready together (same-cycle with bypass).
      step("bypass", 1'b1, 32'h100, $urandom, 1'b1, 1'b0);
      idle("bypass_after");

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 2) != 0), $urandom, $urandom,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      end

      // Asynchronous reset mid-operation drops everything at once.
      step("pre_rst", 1'b1, 32'h300, $urandom, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk1("async_rst.out_valid", out_valid, 1'b0);
      chk1("async_rst.in_ready", in_ready, 1'b1);
      chk1("async_rst.overflow", overflow, 1'b0);
      mq.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 100; i++) begin
         step("rand2", 1'($urandom_range(0, 1)), $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
